// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multi-cycle shift/rotate unit, one bit per clock
// Optional macro SERIAL_SHIFT_ROTATE_EN: mode 11 is ROR when defined, LSR otherwise.
module serial_shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  // A new request is only considered outside SHIFT; this is also what makes
  // back-to-back operation from DONE possible.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = (amount != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == AMT_W'(1)) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shifted = r_data;
    case (r_mode)
      MODE_LSL: w_shifted = {r_data[WIDTH-2:0], serial_in};
      MODE_LSR: w_shifted = {serial_in, r_data[WIDTH-1:1]};
      MODE_ASR: w_shifted = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROTATE_EN
      MODE_ROR: w_shifted = {r_data[0], r_data[WIDTH-1:1]};
`else
      MODE_ROR: w_shifted = {serial_in, r_data[WIDTH-1:1]};
`endif
      default:  w_shifted = r_data;
    endcase
  end

  // busy/done are flopped from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_LSL;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_SHIFT);
      r_done  <= (w_next_state == ST_DONE);
      if (w_accept) begin
        r_data <= data_in;
        r_cnt  <= amount;
        r_mode <= mode;
      end else if (r_state == ST_SHIFT) begin
        r_data <= w_shifted;
        r_cnt  <= r_cnt - AMT_W'(1);
      end
    end
  end

  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Parametrised, multi-cycle shift/rotate unit. It is the sequential successor to the combinational 4-bit shift operator. Operand width, shift-amount width and shift mode are selectable. One bit position is shifted per clock under a small FSM with a start/busy/done handshake. It sits beside datapath blocks that can trade latency for area and need logical, arithmetic and rotate shifts with a serial fill bit.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)
- AMT_W, 4, width of shift amount; amounts 0..2^AMT_W−1 legal, including ≥ WIDTH

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request; sampled only when busy=0
- mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; sampled with start
- amount  input  AMT_W  number of one-bit shift steps; sampled with start
- data_in  input  WIDTH  operand; sampled with start
- serial_in  input  1  fill bit for LSL (enters LSB) and LSR (enters MSB); sampled every shift cycle
- data_out  output  WIDTH  working/result register
- busy  output  1  high in SHIFT state
- done  output  1  one-cycle pulse, result valid

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE. data_out=0, busy=0, done=0.
- IDLE or DONE with start=1 at an edge: data_out←data_in, cnt←amount, mode latched.
  - Next state is SHIFT if amount≠0, else DONE.
- IDLE/DONE with start=0 at an edge: next state IDLE. data_out holds.
- SHIFT, each edge: one-bit shift of data_out per latched mode, cnt←cnt−1.
  - When cnt==1 at that edge, next state is DONE.
- Mode behaviour:
  - LSL: {data_out[WIDTH−2:0], serial_in}
  - LSR: {serial_in, data_out[WIDTH−1:1]}
  - ASR: {data_out[WIDTH−1], data_out[WIDTH−1:1]}
  - ROR: {data_out[0], data_out[WIDTH−1:1]}
- start, mode, amount and data_in are ignored while busy=1. No queueing.
- start in DONE is accepted (back-to-back operation). done is still high in that cycle.
- Amount ≥ WIDTH: stepping continues normally. Logical shifts end all-fill, ASR ends all-sign, ROR wraps modulo WIDTH.
- serial_in may change mid-operation. The value present at each shift edge is used.
- rst_n low at any time, including mid-SHIFT: immediate return to reset values. The operation is abandoned and no done is produced.

## Timing
- Start sampled at edge E0. Shifts occur at edges E1..E_amount.
- done is high for exactly one cycle after edge E_amount. For amount=0 that is the cycle after E0.
- Latency, start-sample to done: amount+1 cycles.
- busy is high from after E0 through edge E_amount. It is never high when amount=0.
- data_out is intermediate while busy=1. It equals the final result while done=1 and holds until the next accepted start.
- Throughput: one operation per amount+1 cycles with back-to-back start.
- All outputs are registered. No combinational input→output paths.

## Configuration
- SERIAL_SHIFT_ROTATE_EN defined: mode 11 performs ROR as specified.
- Not defined: the rotate logic is removed. Mode 11 behaves exactly as LSR, using serial_in as fill. Handshake and timing are unchanged.

## Test plan
Defaults WIDTH=8, AMT_W=4.
- LSL, data_in=0xD3, amount=2, serial_in=0 → data_out=0x4C, done 3 cycles after start, busy high 2 cycles.
- ASR, data_in=0x96, amount=3 → data_out=0xF2, done 4 cycles after start.
- mode=11, data_in=0x0D, amount=1, serial_in=0 → 0x86 with SERIAL_SHIFT_ROTATE_EN, 0x06 without.
- amount=0, data_in=0xA5 → data_out=0xA5, done 1 cycle after start, busy never asserted. Then LSR, amount=9, data_in=0x00, serial_in=1 → 0xFF, done 10 cycles after start.
- start pulsed with data_in=0xFF during busy of LSL 0x01 by 4 → ignored, result 0x10. start issued in the done cycle is accepted, and busy rises on the next cycle.
- rst_n pulled low during the 2nd shift cycle of a 5-step shift → data_out=0, busy=0, done=0 immediately. No done pulse follows. After release, a fresh start works normally.
